ape_perm_iter: RTL and testbench
================================

APE_PERM_ITER -- requirements
Module: ape_perm_iter

Interface
REQ-001 SHALL have parameter W, default 50: state width in bits, at least LO+HI+1.
REQ-002 SHALL have parameter LO, default 20: width of the low segment.
REQ-003 SHALL have parameter HI, default 20: width of the high segment; the middle segment width is MD = W-LO-HI.
REQ-004 SHALL have parameter ROUNDS, default 12: rounds per operation, in the range 1..255.
REQ-005 SHALL have parameter RPC, default 1: rounds per clock; ROUNDS mod RPC SHALL be 0.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: din and mode are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-010 SHALL have port din, input, W bits: input state.
REQ-011 SHALL have port mode, input, 1 bit: 0 = forward, 1 = inverse.
REQ-012 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-013 SHALL have port out_valid, output, 1 bit: dout is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts dout.
REQ-015 SHALL have port dout, output, W bits: result state.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 Forward round i (i = 0..ROUNDS-1) SHALL compute t = {s[LO-1:0], s[W-HI-1:LO], s[W-1:W-HI]}, then XOR rc(i) = i+1 (8 bits, zero-extended) into t[7:0].
REQ-018 Inverse round i SHALL XOR rc(i) into s[7:0] giving u, then produce {u[HI-1:0], u[W-LO-1:HI], u[W-1:W-LO]}.
REQ-019 Inverse operation SHALL apply rounds in order i = ROUNDS-1 down to 0, so inverse(forward(x)) = x for all x.
REQ-020 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-021 in_ready SHALL be 1 only in IDLE while flush = 0.
REQ-022 An accept (in_valid & in_ready at a rising edge) SHALL load din into the state register, latch mode, clear the round counter and enter RUN.
REQ-023 Each cycle in RUN SHALL apply RPC consecutive rounds in the latched direction and advance the round counter by RPC.
REQ-024 When the final round group completes, the FSM SHALL enter DONE with out_valid = 1 exactly ROUNDS/RPC rising edges after the accept edge.
REQ-025 In DONE, dout and out_valid SHALL hold stable until out_ready = 1; the FSM then returns to IDLE on that edge.
REQ-026 No new input SHALL be accepted on the edge that leaves DONE; the next accept is possible one cycle later.
REQ-027 dout SHALL equal the state register at all times; its value outside DONE is don't-care for checking.
REQ-028 flush = 1 at a rising edge SHALL force IDLE from any state, discard the operation and deassert out_valid.
REQ-029 flush SHALL take priority over a simultaneous accept or out_ready handshake.
REQ-030 Changes on din or mode after acceptance SHALL have no effect on the current operation.
REQ-031 The round counter SHALL be 8 bits, SHALL never exceed ROUNDS, and SHALL not wrap.

Reset
REQ-032 rst_n = 0 SHALL immediately, independent of clk, force IDLE, state register = 0, round counter = 0, mode latch = 0, out_valid = 0 and busy = 0.
REQ-033 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no output produced.
REQ-034 in_ready SHALL be 1 from the first cycle after rst_n deasserts, provided flush = 0.

Verification
REQ-035 The bench SHALL cover: ROUNDS = 1, mode = 0, din = 50'h1 -> out_valid 1 edge after accept, dout = 50'h0_0000_4000_0001.
REQ-036 The bench SHALL cover: defaults, din = 50'h2_AAAA_5555_1234 forward, then its dout fed back with mode = 1 -> second dout = 50'h2_AAAA_5555_1234.
REQ-037 The bench SHALL cover: RPC = 4 versus RPC = 1, same din -> identical dout, latency 3 versus 12 cycles.
REQ-038 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and dout stable, in_ready = 0 throughout.
REQ-039 The bench SHALL cover: flush asserted in cycle 6 of RUN together with in_valid = 1 -> IDLE next cycle, no accept, out_valid never 1.
REQ-040 The bench SHALL cover: rst_n pulsed low asynchronously mid-RUN -> out_valid = 0, busy = 0 and state = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ape_perm_iter.sv
// rtl/ape_perm_iter.sv - iterative segment-swap permutation with round constants
// Runs ROUNDS rounds, RPC per clock, forward or inverse; valid/ready in and out.
module ape_perm_iter #(
  parameter int W      = 50,
  parameter int LO     = 20,
  parameter int HI     = 20,
  parameter int ROUNDS = 12,
  parameter int RPC    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  input  logic         mode,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] ROUNDS_C = 8'(ROUNDS);
  localparam logic [7:0] RPC_C    = 8'(RPC);
  localparam logic [7:0] LAST_C   = 8'(ROUNDS - 1);

  logic [1:0]   st_q, st_d;
  logic [W-1:0] s_q, s_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [W-1:0] rnd;
  logic [7:0]   idx;

  // Swap low and high segments, then inject rc = index+1 into the bottom byte.
  function automatic logic [W-1:0] fwd_round(input logic [W-1:0] s, input logic [7:0] ri);
    logic [W-1:0] t;
    t      = {s[LO-1:0], s[W-HI-1:LO], s[W-1:W-HI]};
    t[7:0] = t[7:0] ^ (ri + 8'd1);
    return t;
  endfunction

  function automatic logic [W-1:0] inv_round(input logic [W-1:0] s, input logic [7:0] ri);
    logic [W-1:0] u;
    u      = s;
    u[7:0] = u[7:0] ^ (ri + 8'd1);
    return {u[HI-1:0], u[W-LO-1:HI], u[W-1:W-LO]};
  endfunction

  // Inverse walks the round index downward from ROUNDS-1.
  always_comb begin
    rnd = s_q;
    idx = cnt_q;
    for (int j = 0; j < RPC; j++) begin
      idx = cnt_q + 8'(j);
      if (mode_q) rnd = inv_round(rnd, LAST_C - idx);
      else        rnd = fwd_round(rnd, idx);
    end
  end

  always_comb begin
    st_d   = st_q;
    s_d    = s_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (flush) begin
      st_d  = S_IDLE;
      cnt_d = 8'd0;
    end else begin
      case (st_q)
        S_IDLE: if (in_valid) begin
          s_d    = din;
          mode_d = mode;
          cnt_d  = 8'd0;
          st_d   = S_RUN;
        end
        S_RUN: begin
          s_d   = rnd;
          cnt_d = cnt_q + RPC_C;
          if (cnt_q + RPC_C == ROUNDS_C) st_d = S_DONE;
        end
        S_DONE: if (out_ready) st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      s_q    <= '0;
      cnt_q  <= 8'd0;
      mode_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign in_ready  = (st_q == S_IDLE) && !flush;
  assign out_valid = (st_q == S_DONE);
  assign busy      = (st_q != S_IDLE);
  assign dout      = s_q;

endmodule

// File: tb/tb_ape_perm_iter.sv
// tb/tb_ape_perm_iter.sv - scoreboard bench for ape_perm_iter
// Instances: 0 = defaults, 1 = ROUNDS 1, 2 = RPC 4.
module tb_ape_perm_iter;

  localparam int W = 50;

  typedef struct {
    int           inst;
    logic [W-1:0] data;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv[3], ir[3], md[3], fl[3], ov[3], ordy[3], bz[3];
  logic [W-1:0] di[3], dq[3];

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc[3];
  bit   seen[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ape_perm_iter u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .din(di[0]),
    .mode(md[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .dout(dq[0]), .busy(bz[0])
  );

  ape_perm_iter #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .din(di[1]),
    .mode(md[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .dout(dq[1]), .busy(bz[1])
  );

  ape_perm_iter #(.RPC(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .din(di[2]),
    .mode(md[2]), .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .dout(dq[2]), .busy(bz[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: latency on first out_valid, dout and in_ready every DONE cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (iv[k] && ir[k]) begin
        acc_cyc[k] = cyc;
        seen[k]    = 1'b0;
      end
      if (ov[k]) begin
        if (exp_q.size() == 0 || exp_q[0].inst != k) begin
          chk($sformatf("unexpected_out_%0d", k), 64'(ov[k]), 64'd0);
        end else begin
          if (!seen[k]) begin
            chk($sformatf("latency_%0d", k), 64'(cyc - acc_cyc[k] - 1), 64'(exp_q[0].lat));
            seen[k] = 1'b1;
          end
          chk($sformatf("dout_%0d", k), 64'(dq[k]), 64'(exp_q[0].data));
          chk($sformatf("in_ready_done_%0d", k), 64'(ir[k]), 64'd0);
          if (ordy[k]) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic accept(input int k, input logic [W-1:0] d, input logic m);
    bit got = 1'b0;
    int n = 0;
    iv[k] = 1'b1;
    di[k] = d;
    md[k] = m;
    while (!got && n < 20) begin
      @(negedge clk);
      got = ir[k];
      @(posedge clk);
      #1;
      n++;
    end
    iv[k] = 1'b0;
    di[k] = W'({$urandom, $urandom});
    md[k] = ~m;
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic op(input int k, input logic [W-1:0] d, input logic m, input int lat,
                    input logic [W-1:0] e);
    exp_q.push_back('{inst: k, data: e, lat: lat});
    accept(k, d, m);
    drain();
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; md[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1; di[k] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", 64'(ov[k]), 64'd0);
      chk("reset_busy", 64'(bz[k]), 64'd0);
      chk("reset_dout", 64'(dq[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("in_ready_after_reset", 64'(ir[k]), 64'd1);

    // Twelve rounds of an involutive swap collapse to x ^ 50'h8000_000E.
    op(1, 50'h1, 1'b0, 1, 50'h0_0000_4000_0001);
    op(1, 50'h0_0000_4000_0001, 1'b1, 1, 50'h1);
    op(0, 50'h2_AAAA_5555_1234, 1'b0, 12, 50'h2_AAAA_D555_123A);
    op(0, 50'h2_AAAA_D555_123A, 1'b1, 12, 50'h2_AAAA_5555_1234);
    op(2, 50'h2_AAAA_5555_1234, 1'b0, 3, 50'h2_AAAA_D555_123A);
    op(0, 50'h0, 1'b0, 12, 50'h0_0000_8000_000E);
    op(0, 50'h0, 1'b1, 12, 50'h0_0000_8000_000E);
    op(2, 50'h3_FFFF_FFFF_FFFF, 1'b0, 3, 50'h3_FFFF_7FFF_FFF1);

    // Back-pressure: hold DONE for several cycles.
    ordy[0] = 1'b0;
    exp_q.push_back('{inst: 0, data: 50'h0_0000_8000_000E, lat: 12});
    accept(0, 50'h0, 1'b0);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_reach_done", 64'(ov[0]), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    drain();

    // Flush in RUN cycle 6 with a competing input.
    accept(0, 50'h1234, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    fl[0] = 1'b1; iv[0] = 1'b1; di[0] = 50'h5;
    @(posedge clk);
    #1;
    chk("flush_busy", 64'(bz[0]), 64'd0);
    chk("flush_in_ready", 64'(ir[0]), 64'd0);
    fl[0] = 1'b0; iv[0] = 1'b0;
    #1;
    chk("post_flush_in_ready", 64'(ir[0]), 64'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("flush_no_out", 64'(ov[0]), 64'd0);
    chk("flush_idle", 64'(bz[0]), 64'd0);

    // Asynchronous reset mid-RUN, between clock edges.
    accept(0, 50'h2_AAAA_5555_1234, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(bz[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(ov[0]), 64'd0);
    chk("async_busy", 64'(bz[0]), 64'd0);
    chk("async_state", 64'(dq[0]), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 64'(ir[0]), 64'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("post_reset_no_out", 64'(ov[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
